pipelined_ripple_adder: RTL and testbench
=========================================

// Module: pipelined_ripple_adder
// PURPOSE
//  Parametrised, pipelined successor to the team's combinational ripple adder.
//  - Splits a WIDTH-bit add/subtract into STAGES chunks; the carry is registered between chunks.
//  - Adds a valid/ready handshake on both sides, bubble-collapsing backpressure and a subtract mode.
//  - Sits between operand producers (register file, counters) and downstream datapath consumers.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline stages (= latency in cycles); 1 <= STAGES <= WIDTH
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts operand beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      1: a - b, 0: a + b + cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result beat
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (in sub mode: 1 = no borrow)
//  ovf        out  1      signed overflow; present only with PIPE_ADD_OVF_EN
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert) clears all stage valids and data.
//    out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 from the first cycle after reset.
//  - Arithmetic: sub=1 -> a + ~b + 1 (cin ignored); sub=0 -> a + b + cin. Result is mod 2^WIDTH.
//  - Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//  - Chunking: C = WIDTH/STAGES. Stage k adds bits [k*C +: C] using the carry registered by stage k-1.
//  - Skew/deskew: upper operand chunks are delayed and lower sum chunks are carried forward.
//    This keeps every beat aligned.
//  - Latency: exactly STAGES cycles from the input transfer to out_valid when not stalled.
//    Throughput is 1 beat/cycle.
//  - Stage advance: stage k advances when it is empty or stage k+1 advances.
//    The last stage advances when !out_valid | out_ready. in_ready = stage 0 can advance.
//  - Bubbles collapse; a stalled stage holds all its registers stable.
//  - Ordering: beats are never reordered, dropped or duplicated.
//  - Outputs: sum/cout/ovf are stable while out_valid & !out_ready.
//  - Simultaneous in/out transfer while the pipe is full is legal; no lost cycle.
//  - Reset mid-operation discards all in-flight beats; no partial result appears after reset.
//  - Inputs a, b, cin and sub are ignored (X-safe) when in_valid=0.
// CONFIGURATION
//  PIPE_ADD_OVF_EN defined:
//  - port ovf is present: ovf = (a_msb ^ result_msb) & (b'_msb ^ result_msb).
//  - b' is the operand after sub inversion; ovf is pipelined with its beat.
//  PIPE_ADD_OVF_EN undefined:
//  - port ovf and its pipeline registers are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package pipe_add_pkg:
//    chunk-width function chunk_w(WIDTH,STAGES), stage-valid typedef, SUB/ADD mode constants.
//  - Sub-module add_chunk (parameter C): combinational C-bit ripple adder.
//    Interface: a, b, ci -> s, co; instantiated once per stage via generate.
//  - Top: generate loop of STAGES stage registers, skew/deskew shift registers, handshake logic.
//  - Elaboration check: WIDTH % STAGES != 0 raises a $error.
// TESTING
//  1. WIDTH=32,STAGES=4: a=0xFFFF_FFFF, b=1, cin=0, sub=0
//     -> after 4 cycles sum=0, cout=1 (carry crosses all stages).
//  2. sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1.
//  3. Back-to-back stream of 100 random beats, out_ready=1
//     -> one result per cycle, all match the model, order preserved.
//  4. out_ready=0 for 10 cycles with in_valid=1
//     -> exactly 4 beats accepted then in_ready=0 with outputs held.
//     Releasing out_ready drains in order.
//  5. rst_n pulsed low with 3 beats in flight
//     -> out_valid=0 immediately; no stale beat emerges after reset.
//  6. PIPE_ADD_OVF_EN: a=0x7FFF_FFFF, b=1, sub=0 -> ovf=1.
//     sub=1, a=0x8000_0000, b=1 -> ovf=1; a=1, b=1, sub=1 -> ovf=0.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared types and helpers for the pipelined ripple adder.
// The top enables its signed-overflow output when PIPE_ADD_OVF_EN is defined.
package pipe_add_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // One valid flag per pipeline stage.
    typedef logic stage_vld_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational C-bit ripple-carry adder used as the per-stage slice of the pipelined adder.
module add_chunk #(
    parameter int C = 8
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         ci,
    output logic [C-1:0] s,
    output logic         co
);

    logic [C:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < C; i++) begin : g_bit
        assign s[i]           = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign co = carry_s[C];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple chunks with a registered carry between chunks.
// Define PIPE_ADD_OVF_EN to add the pipelined signed-overflow output ovf.
module pipelined_ripple_adder
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int C = chunk_w(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
    end

    // Every stage carries the full operands and partial sum; untouched bits are pruned by synthesis.
    logic [WIDTH-1:0]          a_q [STAGES];
    logic [WIDTH-1:0]          b_q [STAGES];
    logic [WIDTH-1:0]          s_q [STAGES];
    logic [STAGES-1:0]         c_q;
    stage_vld_t [STAGES-1:0]   v_q;

    logic [WIDTH-1:0]          st_a_s [STAGES];
    logic [WIDTH-1:0]          st_b_s [STAGES];
    logic [WIDTH-1:0]          st_s_s [STAGES];
    logic [WIDTH-1:0]          s_d    [STAGES];
    logic [STAGES-1:0]         st_c_s;
    logic [STAGES-1:0]         st_v_s;
    logic [STAGES-1:0]         co_s;
    logic [STAGES-1:0]         adv_s;
    logic [STAGES-1:0]         ld_s;
    logic [C-1:0]              chunk_s [STAGES];

    // Stage inputs: stage 0 sees the ports (b inverted in subtract mode), later stages their predecessor.
    always_comb begin
        st_a_s = '{default: {WIDTH{1'b0}}};
        st_b_s = '{default: {WIDTH{1'b0}}};
        st_s_s = '{default: {WIDTH{1'b0}}};
        st_c_s = {STAGES{1'b0}};
        st_v_s = {STAGES{1'b0}};
        st_a_s[0] = a;
        st_b_s[0] = (sub == MODE_SUB) ? ~b : b;
        st_c_s[0] = (sub == MODE_SUB) ? 1'b1 : cin;
        st_v_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a_s[k] = a_q[k-1];
            st_b_s[k] = b_q[k-1];
            st_s_s[k] = s_q[k-1];
            st_c_s[k] = c_q[k-1];
            st_v_s[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(.C(C)) u_chunk (
            .a  (st_a_s[k][k*C +: C]),
            .b  (st_b_s[k][k*C +: C]),
            .ci (st_c_s[k]),
            .s  (chunk_s[k]),
            .co (co_s[k])
        );
    end

    // A stage advances unless it and every stage after it are full while the output is blocked.
    always_comb begin
        logic all_v;
        all_v = 1'b1;
        adv_s = {STAGES{1'b0}};
        ld_s  = {STAGES{1'b0}};
        s_d   = '{default: {WIDTH{1'b0}}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_v    = all_v & v_q[k];
            adv_s[k] = out_ready | ~all_v;
        end
        for (int k = 0; k < STAGES; k++) begin
            ld_s[k]          = adv_s[k] & st_v_s[k];
            s_d[k]           = st_s_s[k];
            s_d[k][k*C +: C] = chunk_s[k];
        end
    end

    // Stage registers: valids move on advance, data only loads with a real beat so bubbles stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= {STAGES{1'b0}};
            c_q <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                s_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv_s[k]) begin
                    v_q[k] <= st_v_s[k];
                end
                if (ld_s[k]) begin
                    a_q[k] <= st_a_s[k];
                    b_q[k] <= st_b_s[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= co_s[k];
                end
            end
        end
    end

`ifdef PIPE_ADD_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Overflow: both addends share a sign that differs from the result; b is already inverted for sub.
    always_comb begin
        ovf_d = (st_a_s[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1]) &
                (st_b_s[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1]);
    end

    // Overflow flag registered alongside the final stage of its beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ld_s[STAGES-1]) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = adv_s[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (WIDTH=32, STAGES=4) with a queue-based reference.
// Define PIPE_ADD_OVF_EN to also exercise the overflow output.
module tb_pipelined_ripple_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_obs;
`ifdef PIPE_ADD_OVF_EN
    logic         ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    res_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        res_t        r;
        logic [W:0]  wide;
        longint      sa;
        longint      sb;
        longint      sr;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            r.s = ma - mb;
            r.c = (ma >= mb);
            sr  = sa - sb;
        end else begin
            wide = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            r.s  = wide[W-1:0];
            r.c  = wide[W];
            sr   = sa + sb + (mcin ? 64'sd1 : 64'sd0);
        end
`ifdef PIPE_ADD_OVF_EN
        r.o = (sr != longint'($signed(r.s)));
`else
        r.o = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score transfers at the negedge, then return #1 after the next posedge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("out_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_out++;
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf_obs, e.o);
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic vsub);
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vcin;
        sub = vsub;
    endtask

    task automatic wait_out(input string tag);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            cycle();
            k++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 50) begin
            cycle();
            k++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int lat;
        int acc;
        int out0;
        logic [W-1:0] held_s;
        logic held_c;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf_obs, 0);
        rst_n = 1'b1;
        cycle();
        chk("rst_in_ready", in_ready, 1);

        // Carry ripples through every chunk; measure latency.
        out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        chk("latency", lat, S);
        chk("carry_all_sum", sum, 32'h0000_0000);
        chk("carry_all_cout", cout, 1);
        drain();

        // Subtract with and without borrow.
        drive(32'd5, 32'd7, 1'b1, 1'b1);
        cycle();
        drive(32'd7, 32'd5, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        wait_out("sub_wait");
        chk("sub_5m7_sum", sum, 32'hFFFF_FFFE);
        chk("sub_5m7_cout", cout, 0);
        cycle();
        chk("sub_7m5_sum", sum, 32'd2);
        chk("sub_7m5_cout", cout, 1);
        drain();

`ifdef PIPE_ADD_OVF_EN
        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        cycle();
        drive(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        cycle();
        drive(32'd1, 32'd1, 1'b0, 1'b1);
        cycle();
        in_valid = 1'b0;
        wait_out("ovf_wait");
        chk("ovf_add_pos", ovf, 1);
        cycle();
        chk("ovf_sub_neg", ovf, 1);
        cycle();
        chk("ovf_sub_zero", ovf, 0);
        drain();
`endif

        // Back-to-back random stream with the consumer always ready.
        out0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("stream_in_ready", in_ready, 1);
            cycle();
        end
        drain();
        chk("stream_count", n_out - out0, 100);

        // Backpressure: only S beats fit, then outputs hold.
        out_ready = 1'b0;
        acc = 0;
        held_s = '0;
        held_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (in_ready) acc++;
            cycle();
            if (i == 5) begin
                held_s = sum;
                held_c = cout;
            end
        end
        chk("bp_accepted", acc, S);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_sum", sum, held_s);
        chk("bp_hold_cout", cout, held_c);
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("postrst_no_stale", out_valid, 0);
            cycle();
        end
        drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cycle();
        out0 = n_out;
        drain();
        chk("postrst_beat", n_out - out0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
